// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/bubble defaults, PCSrc encodings used by
// Control and the fetch stage, and the IF/ID update action.
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_JUMP = 2'b01;
   localparam logic [1:0] PCSRC_JR   = 2'b11;

   // What the IF/ID register does on the coming edge
   typedef enum logic [1:0] {
      ACT_FETCH  = 2'b00,
      ACT_HOLD   = 2'b01,
      ACT_BUBBLE = 2'b10
   } ifid_act_e;

   // Pseudo-direct j/jal target: upper PC nibble, 26-bit index, word aligned
   function automatic logic [31:0] jump_target(input logic [3:0]  pcp4_hi,
                                               input logic [25:0] idx);
      return {pcp4_hi, idx, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory.
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;

   modport master (output imem_addr, input  imem_rdata);
   modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC priority selector (combinational): branch > stall > redirect
// from ID > sequential. Reset is applied by the registers in the top.
module pc_next_sel
   import cpu_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   input  logic        stall_i,
   input  logic [1:0]  pc_src_id_i,
   input  logic [31:0] jr_target_id_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_taken_ex_i,
   input  logic [31:0] branch_target_ex_i,
   input  logic        if_id_valid_i,
   output logic [31:0] pc_d_o,
   output ifid_act_e   act_o
);

   // Resolve one winner per cycle; a bubble in ID never redirects
   always_comb begin
      pc_d_o = pc_plus4_i;
      act_o  = ACT_FETCH;
      if (branch_taken_ex_i) begin
         pc_d_o = branch_target_ex_i;
         act_o  = ACT_BUBBLE;
      end else if (stall_i) begin
         pc_d_o = pc_i;
         act_o  = ACT_HOLD;
      end else if (if_id_valid_i && (pc_src_id_i == PCSRC_JUMP)) begin
         pc_d_o = jump_target_i;
         act_o  = ACT_BUBBLE;
      end else if (if_id_valid_i && (pc_src_id_i == PCSRC_JR)) begin
         pc_d_o = jr_target_id_i;
         act_o  = ACT_BUBBLE;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// instruction-memory address. Optional feature macro FETCH_PERF_CNT_EN
// adds a fetch_count output counting valid instructions entering IF/ID.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic [1:0]   pc_src_id,
   input  logic [31:0]  jr_target_id,
   input  logic         branch_taken_ex,
   input  logic [31:0]  branch_target_ex,
   fetch_stage_if.master imem,
   output logic [31:0]  if_id_instr,
   output logic [31:0]  if_id_pc_plus4,
   output logic         if_id_valid,
   output logic [5:0]   opcode,
   output logic [5:0]   funct
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  fetch_count
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_plus4;
   logic [31:0] jump_tgt;
   ifid_act_e   act;

   assign pc_plus4 = pc_q + 32'd4;
   assign jump_tgt = jump_target(pcp4_q[31:28], instr_q[25:0]);

   pc_next_sel u_sel (
      .pc_i               (pc_q),
      .pc_plus4_i         (pc_plus4),
      .stall_i            (stall),
      .pc_src_id_i        (pc_src_id),
      .jr_target_id_i     (jr_target_id),
      .jump_target_i      (jump_tgt),
      .branch_taken_ex_i  (branch_taken_ex),
      .branch_target_ex_i (branch_target_ex),
      .if_id_valid_i      (valid_q),
      .pc_d_o             (pc_d),
      .act_o              (act)
   );

   // IF/ID next contents: capture the fetched word, hold, or insert a bubble
   always_comb begin
      instr_d = imem.imem_rdata;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
      case (act)
         ACT_HOLD: begin
            instr_d = instr_q;
            pcp4_d  = pcp4_q;
            valid_d = valid_q;
         end
         ACT_BUBBLE: begin
            instr_d = NOP_INSTR;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   // PC and IF/ID registers; reset overrides every other request
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcp4_q  <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cnt_q;

   // Count only cycles where a real instruction is captured into IF/ID
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= 32'd0;
      else if (act == ACT_FETCH)
         cnt_q <= cnt_q + 32'd1;
   end

   assign fetch_count = cnt_q;
`endif

   assign imem.imem_addr  = pc_q;
   assign if_id_instr     = instr_q;
   assign if_id_pc_plus4  = pcp4_q;
   assign if_id_valid     = valid_q;
   assign opcode          = instr_q[31:26];
   assign funct           = instr_q[5:0];

endmodule
